systolic_seq_ctrl: RTL and testbench
====================================

Name: systolic_seq_ctrl

Overview:
- Job sequencer that sits in front of one systolic_array instance.
- Accepts one N×N job per run: N beats, each beat carrying one row of A and one column of B. Buffers the job, clears the array accumulators, and drives the skewed wavefront into the array.
- Captures the N result rows the array emits, which cannot be stalled, then streams them out under valid/ready backpressure.

Parameters:
- DATAWIDTH, 16, operand width (signed).
- N_SIZE, 5, array dimension. Legal range 2..8.
- WAIT_MAX, 64, drain watchdog limit in cycles.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ld_valid  in  1  load beat valid.
- ld_ready  out  1  load beat accepted when ld_valid && ld_ready.
- ld_a_row  in  N_SIZE*DATAWIDTH  row k of A; lane i is at [i*DATAWIDTH +: DATAWIDTH].
- ld_b_col  in  N_SIZE*DATAWIDTH  column k of B; lane j holds B[j][k].
- arr_clr_n  out  1  active-low accumulator clear to the array's rst_n; ANDed with rst_n externally.
- arr_valid_in  out  1  array valid_in.
- arr_a  out  N_SIZE*DATAWIDTH  array matrix_a_in.
- arr_b  out  N_SIZE*DATAWIDTH  array matrix_b_in.
- arr_valid_out  in  1  array valid_out.
- arr_c  in  N_SIZE*2*DATAWIDTH  array matrix_c_out.
- res_valid  out  1  result row valid.
- res_ready  in  1  downstream accept.
- res_row  out  N_SIZE*2*DATAWIDTH  captured result row.
- res_idx  out  clog2(N_SIZE)  slot index of res_row.
- res_last  out  1  asserted with the final row.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky watchdog error.

Behaviour:
- Reset values: all outputs 0, except arr_clr_n=1. State=IDLE. Buffers are not reset.
- States and transitions:
  - IDLE: ld_ready=1. The first accepted beat is stored as k=0 and the state moves to LOAD.
  - LOAD: ld_ready=1. Beats are stored at k=1..N_SIZE-1. After beat N_SIZE-1 is accepted, go to CLEAR.
  - CLEAR: exactly one cycle with arr_clr_n=0 and ld_ready=0. Then go to FEED with step t=0.
  - FEED: 2*N_SIZE-1 cycles, t=0..2*N_SIZE-2, with arr_valid_in=1 throughout.
    - Lane i of arr_a = A[i][t-i] when 0≤t-i<N_SIZE, else 0.
    - Lane j of arr_b = B[t-j][j] when 0≤t-j<N_SIZE, else 0.
    - arr_a and arr_b are registered. After the last step, go to DRAIN with capture count r=0 and watchdog w=0.
  - DRAIN: arr_valid_in=0. Each cycle with arr_valid_out=1 captures arr_c into slot r and increments r. When r reaches N_SIZE, go to UNLOAD.
    - w increments on every DRAIN cycle without a capture. If w reaches WAIT_MAX, set err and go to IDLE, discarding the job.
  - UNLOAD: res_valid=1 and res_row=slot[u], res_idx=u, res_last=(u==N_SIZE-1).
    - u advances only when res_valid && res_ready.
    - Accepting the last row returns the state to IDLE.
    - res_row must remain stable while res_valid=1 && !res_ready.
- ld_ready is 0 in CLEAR, FEED, DRAIN and UNLOAD. ld_valid is ignored while ld_ready=0.
- Any arr_valid_out seen outside DRAIN is ignored.
- err clears only on rst_n.
- Latency: the first res_valid follows the last load beat by 1 (CLEAR) + 2N-1 (FEED) + the array's drain time.
- Slots hold rows in arrival order. The row mapping is defined by the array.
- Widths: pure data movement, no arithmetic on operands. Counters are sized to hold 2*N_SIZE and WAIT_MAX.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. A partially loaded job is lost.

Decomposition:
- Package systolic_pkg contains:
  - state enum (IDLE, LOAD, CLEAR, FEED, DRAIN, UNLOAD);
  - the lane-slice helper function;
  - the skew-index localparams.
- One sub-module: systolic_skew_gen. It takes the A/B buffers and step t, and produces the registered skewed arr_a and arr_b.
- The top level holds the FSM, the load and result buffers, the counters and the handshakes.

Test Plan:
- N_SIZE=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], res_ready=1 → with a real systolic_array attached, captured rows {19,22} and {43,50} appear in array order, res_last on the second row, busy falls afterwards.
- Skew check, N_SIZE=3: capture arr_a and arr_b during FEED → exactly 5 cycles of arr_valid_in. At t=0 only lane 0 is nonzero. At t=4 only lane 2 is nonzero and holds A[2][2] / B[2][2].
- Back-to-back jobs, identity A then A=2·I, same B → the second result equals 2·B. This confirms arr_clr_n pulsed low for one cycle before the second FEED.
- Backpressure: res_ready toggles 0,0,1 repeatedly → each row is held stable until accepted. No row is lost or duplicated, and res_idx runs 0..N-1.
- Watchdog: arr_valid_out tied to 0, WAIT_MAX=64 → err=1 and state IDLE exactly 64 DRAIN cycles after FEED ends. ld_ready returns to 1.
- Reset asserted mid-FEED (t=2) → all outputs go to reset values asynchronously. After release, a fresh job completes correctly.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic job sequencer: FSM states,
// counter widths sized for the largest legal array, and lane slicing.
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CLEAR  = 3'd2,
        FEED   = 3'd3,
        DRAIN  = 3'd4,
        UNLOAD = 3'd5
    } state_e;

    // Widths sized for N_SIZE up to N_MAX: step t runs to 2*N-2, row indices to N.
    localparam int unsigned N_MAX  = 8;
    localparam int unsigned STEP_W = $clog2(2 * N_MAX + 1);
    localparam int unsigned IDX_W  = $clog2(N_MAX + 1);

    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// Registered wavefront generator: lane i of A and lane j of B are delayed by
// their lane index so operand k of every row/column meets in the right PE.
module systolic_skew_gen
    import systolic_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int N_SIZE    = 5
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 feed_en,
    input  logic [STEP_W-1:0]                    step,
    input  logic [N_SIZE*N_SIZE*DATAWIDTH-1:0]   a_buf,
    input  logic [N_SIZE*N_SIZE*DATAWIDTH-1:0]   b_buf,
    output logic [N_SIZE*DATAWIDTH-1:0]          arr_a,
    output logic [N_SIZE*DATAWIDTH-1:0]          arr_b
);

    localparam int ROW_W = N_SIZE * DATAWIDTH;

    logic [ROW_W-1:0] arr_a_d, arr_b_d, arr_a_q, arr_b_q;

    // Beat i of each buffer holds A row i / B column i; lane t-i of that beat is due at step t.
    always_comb begin
        arr_a_d = '0;
        arr_b_d = '0;
        for (int i = 0; i < N_SIZE; i++) begin
            int k;
            k = int'(step) - i;
            if (feed_en && (k >= 0) && (k < N_SIZE)) begin
                arr_a_d[lane_lo(i, DATAWIDTH) +: DATAWIDTH] = a_buf[lane_lo(i * N_SIZE + k, DATAWIDTH) +: DATAWIDTH];
                arr_b_d[lane_lo(i, DATAWIDTH) +: DATAWIDTH] = b_buf[lane_lo(i * N_SIZE + k, DATAWIDTH) +: DATAWIDTH];
            end else begin
                arr_a_d[lane_lo(i, DATAWIDTH) +: DATAWIDTH] = {DATAWIDTH{1'b0}};
                arr_b_d[lane_lo(i, DATAWIDTH) +: DATAWIDTH] = {DATAWIDTH{1'b0}};
            end
        end
    end

    // Operand output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arr_a_q <= '0;
            arr_b_q <= '0;
        end else begin
            arr_a_q <= arr_a_d;
            arr_b_q <= arr_b_d;
        end
    end

    assign arr_a = arr_a_q;
    assign arr_b = arr_b_q;

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for one systolic array: buffers an N-beat job, clears the
// accumulators, feeds the skewed wavefront, captures and streams out results.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int N_SIZE    = 5,
    parameter int WAIT_MAX  = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            ld_valid,
    output logic                            ld_ready,
    input  logic [N_SIZE*DATAWIDTH-1:0]     ld_a_row,
    input  logic [N_SIZE*DATAWIDTH-1:0]     ld_b_col,
    output logic                            arr_clr_n,
    output logic                            arr_valid_in,
    output logic [N_SIZE*DATAWIDTH-1:0]     arr_a,
    output logic [N_SIZE*DATAWIDTH-1:0]     arr_b,
    input  logic                            arr_valid_out,
    input  logic [N_SIZE*2*DATAWIDTH-1:0]   arr_c,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [N_SIZE*2*DATAWIDTH-1:0]   res_row,
    output logic [$clog2(N_SIZE)-1:0]       res_idx,
    output logic                            res_last,
    output logic                            busy,
    output logic                            err
);

    localparam int ROW_W  = N_SIZE * DATAWIDTH;
    localparam int RES_W  = N_SIZE * 2 * DATAWIDTH;
    localparam int RIDX_W = $clog2(N_SIZE);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_SIZE - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2 * N_SIZE - 2);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_MAX - 1);

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         k_q, k_d, r_q, r_d, u_q, u_d;
    logic [STEP_W-1:0]        t_q, t_d;
    logic [WAIT_W-1:0]        w_q, w_d;
    logic                     err_q, err_d;
    logic [N_SIZE*ROW_W-1:0]  a_buf_q, a_buf_d, b_buf_q, b_buf_d;
    logic [N_SIZE*RES_W-1:0]  slot_q, slot_d;
    logic                     ld_ready_q, ld_ready_d, arr_clr_n_q, arr_clr_n_d;
    logic                     arr_valid_in_q, arr_valid_in_d, busy_q, busy_d;
    logic                     res_valid_q, res_valid_d, res_last_q, res_last_d;
    logic [RES_W-1:0]         res_row_q, res_row_d;
    logic [RIDX_W-1:0]        res_idx_q, res_idx_d;
    logic                     ld_fire, res_fire;

    // Next-state, buffer update and next-output logic.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        t_d      = t_q;
        r_d      = r_q;
        w_d      = w_q;
        u_d      = u_q;
        err_d    = err_q;
        a_buf_d  = a_buf_q;
        b_buf_d  = b_buf_q;
        slot_d   = slot_q;
        ld_fire  = ld_valid && ld_ready_q;
        res_fire = res_valid_q && res_ready;

        case (state_q)
            IDLE, LOAD: begin
                if (ld_fire) begin
                    a_buf_d[lane_lo(int'(k_q), ROW_W) +: ROW_W] = ld_a_row;
                    b_buf_d[lane_lo(int'(k_q), ROW_W) +: ROW_W] = ld_b_col;
                    if (k_q == LAST_IDX) begin
                        k_d     = '0;
                        state_d = CLEAR;
                    end else begin
                        k_d     = k_q + IDX_W'(1);
                        state_d = LOAD;
                    end
                end else begin
                    k_d = k_q;
                end
            end
            CLEAR: begin
                t_d     = '0;
                state_d = FEED;
            end
            FEED: begin
                if (t_q == LAST_STEP) begin
                    r_d     = '0;
                    w_d     = '0;
                    state_d = DRAIN;
                end else begin
                    t_d = t_q + STEP_W'(1);
                end
            end
            DRAIN: begin
                if (arr_valid_out) begin
                    slot_d[lane_lo(int'(r_q), RES_W) +: RES_W] = arr_c;
                    if (r_q == LAST_IDX) begin
                        r_d     = '0;
                        u_d     = '0;
                        state_d = UNLOAD;
                    end else begin
                        r_d = r_q + IDX_W'(1);
                    end
                end else if (w_q == LAST_WAIT) begin
                    // The array never finished: drop the job and flag it until reset.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    w_d = w_q + WAIT_W'(1);
                end
            end
            UNLOAD: begin
                if (res_fire) begin
                    if (u_q == LAST_IDX) begin
                        u_d     = '0;
                        state_d = IDLE;
                    end else begin
                        u_d = u_q + IDX_W'(1);
                    end
                end else begin
                    u_d = u_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ld_ready_d     = (state_d == IDLE) || (state_d == LOAD);
        arr_clr_n_d    = (state_d != CLEAR);
        arr_valid_in_d = (state_d == FEED);
        busy_d         = (state_d != IDLE);
        res_valid_d    = (state_d == UNLOAD);
        if (state_d == UNLOAD) begin
            res_row_d  = slot_d[lane_lo(int'(u_d), RES_W) +: RES_W];
            res_idx_d  = u_d[RIDX_W-1:0];
            res_last_d = (u_d == LAST_IDX);
        end else begin
            res_row_d  = '0;
            res_idx_d  = '0;
            res_last_d = 1'b0;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            k_q            <= '0;
            t_q            <= '0;
            r_q            <= '0;
            w_q            <= '0;
            u_q            <= '0;
            err_q          <= 1'b0;
            ld_ready_q     <= 1'b0;
            arr_clr_n_q    <= 1'b1;
            arr_valid_in_q <= 1'b0;
            busy_q         <= 1'b0;
            res_valid_q    <= 1'b0;
            res_row_q      <= '0;
            res_idx_q      <= '0;
            res_last_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            t_q            <= t_d;
            r_q            <= r_d;
            w_q            <= w_d;
            u_q            <= u_d;
            err_q          <= err_d;
            ld_ready_q     <= ld_ready_d;
            arr_clr_n_q    <= arr_clr_n_d;
            arr_valid_in_q <= arr_valid_in_d;
            busy_q         <= busy_d;
            res_valid_q    <= res_valid_d;
            res_row_q      <= res_row_d;
            res_idx_q      <= res_idx_d;
            res_last_q     <= res_last_d;
        end
    end

    // Job and result storage; contents are only meaningful once written.
    always_ff @(posedge clk) begin
        a_buf_q <= a_buf_d;
        b_buf_q <= b_buf_d;
        slot_q  <= slot_d;
    end

    systolic_skew_gen #(
        .DATAWIDTH (DATAWIDTH),
        .N_SIZE    (N_SIZE)
    ) u_skew (
        .clk     (clk),
        .rst_n   (rst_n),
        .feed_en (state_d == FEED),
        .step    (t_d),
        .a_buf   (a_buf_q),
        .b_buf   (b_buf_q),
        .arr_a   (arr_a),
        .arr_b   (arr_b)
    );

    assign ld_ready     = ld_ready_q;
    assign arr_clr_n    = arr_clr_n_q;
    assign arr_valid_in = arr_valid_in_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign res_valid    = res_valid_q;
    assign res_row      = res_row_q;
    assign res_idx      = res_idx_q;
    assign res_last     = res_last_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl (N=3) with a behavioural output-stationary array
// model; expected products are hand-computed constants in the vector table.
module tb_systolic_seq_ctrl;

    localparam int N   = 3;
    localparam int DW  = 16;
    localparam int WM  = 64;
    localparam int DLY = N;

    typedef logic signed [0:8][31:0] mat_t;
    typedef struct packed {
        mat_t a;
        mat_t b;
        mat_t c;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  ld_valid = 1'b0;
    logic                  ld_ready;
    logic [N*DW-1:0]       ld_a_row = '0;
    logic [N*DW-1:0]       ld_b_col = '0;
    logic                  arr_clr_n;
    logic                  arr_valid_in;
    logic [N*DW-1:0]       arr_a;
    logic [N*DW-1:0]       arr_b;
    logic                  arr_valid_out;
    logic [N*2*DW-1:0]     arr_c;
    logic                  res_valid;
    logic                  res_ready = 1'b0;
    logic [N*2*DW-1:0]     res_row;
    logic [$clog2(N)-1:0]  res_idx;
    logic                  res_last;
    logic                  busy;
    logic                  err;

    int checks = 0;
    int failures = 0;
    logic mute = 1'b0;
    logic stray = 1'b0;
    vec_t vecs [4];

    systolic_seq_ctrl #(.DATAWIDTH(DW), .N_SIZE(N), .WAIT_MAX(WM)) dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_a_row(ld_a_row), .ld_b_col(ld_b_col), .arr_clr_n(arr_clr_n),
        .arr_valid_in(arr_valid_in), .arr_a(arr_a), .arr_b(arr_b),
        .arr_valid_out(arr_valid_out), .arr_c(arr_c), .res_valid(res_valid),
        .res_ready(res_ready), .res_row(res_row), .res_idx(res_idx),
        .res_last(res_last), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural array: A flows right, B flows down, each PE accumulates a*b.
    logic signed [DW-1:0] ap [N][N];
    logic signed [DW-1:0] bp [N][N];
    logic signed [DW-1:0] ain [N][N];
    logic signed [DW-1:0] bin [N][N];
    int acc [N][N];
    int dcnt;
    logic armed;
    logic mdl_vo;
    int mdl_row;
    wire clr_n_s = rst_n & arr_clr_n;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ain[i][0] = arr_a[i*DW +: DW];
            bin[0][i] = arr_b[i*DW +: DW];
            for (int j = 1; j < N; j++) begin
                ain[i][j] = ap[i][j-1];
                bin[j][i] = bp[j-1][i];
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n_s) begin
        if (!clr_n_s) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ap[i][j]  <= '0;
                    bp[i][j]  <= '0;
                    acc[i][j] <= 0;
                end
        end else begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ap[i][j]  <= ain[i][j];
                    bp[i][j]  <= bin[i][j];
                    acc[i][j] <= acc[i][j] + int'(ain[i][j]) * int'(bin[i][j]);
                end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt <= 0; armed <= 1'b0; mdl_vo <= 1'b0; mdl_row <= 0;
        end else if (arr_valid_in) begin
            dcnt <= 0; armed <= 1'b1; mdl_vo <= 1'b0;
        end else if (armed) begin
            dcnt <= dcnt + 1;
            mdl_vo <= (dcnt >= DLY) && (dcnt < DLY + N) && !mute;
            mdl_row <= (dcnt >= DLY && dcnt < DLY + N) ? dcnt - DLY : 0;
            if (dcnt == DLY + N) armed <= 1'b0;
        end else begin
            mdl_vo <= 1'b0;
        end
    end

    always_comb begin
        for (int j = 0; j < N; j++) arr_c[j*2*DW +: 2*DW] = acc[mdl_row][j];
    end
    assign arr_valid_out = mdl_vo | stray;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic mat_t mk(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
        return {e0, e1, e2, e3, e4, e5, e6, e7, e8};
    endfunction

    function automatic logic [N*DW-1:0] exp_a(input mat_t m, input int t);
        logic [N*DW-1:0] v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[i*DW +: DW] = m[i*3 + (t - i)][DW-1:0];
        return v;
    endfunction

    function automatic logic [N*DW-1:0] exp_b(input mat_t m, input int t);
        logic [N*DW-1:0] v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[j*DW +: DW] = m[(t - j)*3 + j][DW-1:0];
        return v;
    endfunction

    function automatic logic [N*2*DW-1:0] exp_row(input mat_t c, input int r);
        logic [N*2*DW-1:0] v;
        for (int j = 0; j < N; j++) v[j*2*DW +: 2*DW] = c[r*3 + j];
        return v;
    endfunction

    task automatic send_job(input mat_t a, input mat_t b);
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) ld_a_row[i*DW +: DW] = a[k*3 + i][DW-1:0];
            for (int j = 0; j < N; j++) ld_b_col[j*DW +: DW] = b[j*3 + k][DW-1:0];
            ld_valid = 1'b1;
            for (int n = 0; n < 50 && !ld_ready; n++) tick();
            chk("ld_ready_wait", ld_ready, 1);
            tick();
        end
        ld_valid = 1'b0;
        ld_a_row = '0;
        ld_b_col = '0;
    endtask

    task automatic feed_check(input int v);
        chk("clear_pulse", arr_clr_n, 0);
        chk("clear_ld_ready", ld_ready, 0);
        tick();
        for (int t = 0; t < 2*N - 1; t++) begin
            chk("feed_valid", arr_valid_in, 1);
            chk("feed_clr_high", arr_clr_n, 1);
            chk("feed_ld_ready", ld_ready, 0);
            chk("feed_arr_a", arr_a, exp_a(vecs[v].a, t));
            chk("feed_arr_b", arr_b, exp_b(vecs[v].b, t));
            tick();
        end
        chk("feed_done", arr_valid_in, 0);
    endtask

    task automatic run_job(input int v, input bit bp);
        send_job(vecs[v].a, vecs[v].b);
        feed_check(v);
        for (int n = 0; n < 100 && !res_valid; n++) tick();
        for (int r = 0; r < N; r++) begin
            if (bp) begin
                for (int h = 0; h < 2; h++) begin
                    res_ready = 1'b0;
                    chk("hold_valid", res_valid, 1);
                    chk("hold_idx", res_idx, r);
                    chk("hold_row", res_row, exp_row(vecs[v].c, r));
                    tick();
                end
            end
            res_ready = 1'b1;
            chk("res_valid", res_valid, 1);
            chk("res_idx", res_idx, r);
            chk("res_row", res_row, exp_row(vecs[v].c, r));
            chk("res_last", res_last, (r == N - 1));
            tick();
            res_ready = 1'b0;
        end
        chk("done_busy", busy, 0);
        chk("done_res_valid", res_valid, 0);
    endtask

    initial begin
        vecs[0] = '{a: mk(1,0,0, 0,1,0, 0,0,1), b: mk(1,2,3, 4,5,6, 7,8,9),
                    c: mk(1,2,3, 4,5,6, 7,8,9)};
        vecs[1] = '{a: mk(2,0,0, 0,2,0, 0,0,2), b: mk(1,2,3, 4,5,6, 7,8,9),
                    c: mk(2,4,6, 8,10,12, 14,16,18)};
        vecs[2] = '{a: mk(1,2,3, 4,5,6, 7,8,9), b: mk(9,8,7, 6,5,4, 3,2,1),
                    c: mk(30,24,18, 84,69,54, 138,114,90)};
        vecs[3] = '{a: mk(-1,0,2, 3,-2,1, 0,1,-1), b: mk(2,-3,1, 0,4,-2, -1,1,5),
                    c: mk(-4,5,9, 5,-16,12, 1,3,-7)};

        #2 rst_n = 1'b0;
        tick();
        tick();
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_clr_n", arr_clr_n, 1);
        chk("rst_valid_in", arr_valid_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_res_valid", res_valid, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_ld_ready", ld_ready, 1);

        // Identity then 2*I against the same B: second job only matches if accumulators were cleared.
        run_job(0, 1'b0);
        run_job(1, 1'b0);
        run_job(2, 1'b1);

        // Watchdog: array never answers.
        mute = 1'b1;
        send_job(vecs[3].a, vecs[3].b);
        for (int n = 0; n < 2*N; n++) tick();
        chk("wd_drain_entry", arr_valid_in, 0);
        for (int n = 0; n < WM - 1; n++) tick();
        chk("wd_err_early", err, 0);
        chk("wd_busy_early", busy, 1);
        tick();
        chk("wd_err", err, 1);
        chk("wd_busy", busy, 0);
        chk("wd_ld_ready", ld_ready, 1);
        mute = 1'b0;

        stray = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("stray_busy", busy, 0);
            chk("stray_res_valid", res_valid, 0);
        end
        stray = 1'b0;
        chk("err_sticky", err, 1);

        // Reset in the middle of FEED at t=2.
        send_job(vecs[2].a, vecs[2].b);
        tick();
        tick();
        tick();
        chk("mid_feed_t2", arr_a, exp_a(vecs[2].a, 2));
        #2 rst_n = 1'b0;
        #1;
        chk("mr_ld_ready", ld_ready, 0);
        chk("mr_clr_n", arr_clr_n, 1);
        chk("mr_valid_in", arr_valid_in, 0);
        chk("mr_arr_a", arr_a, 0);
        chk("mr_arr_b", arr_b, 0);
        chk("mr_busy", busy, 0);
        chk("mr_err", err, 0);
        chk("mr_res_valid", res_valid, 0);
        chk("mr_res_row", res_row, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_job(3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
